// File: rtl/act_loader_pkg.sv
// Shared types and constants for the activation loader and its raster counter.
// Padding support is selected in act_loader with the ACT_LOADER_PAD_EN macro.
package act_loader_pkg;

  localparam int IDX_WIDTH = 16;

  typedef logic [IDX_WIDTH-1:0] idx_t;
  typedef logic [1:0]           state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int pad_of(input int kernel_dim);
    return kernel_dim / 2;
  endfunction

endpackage

// File: rtl/act_loader_raster_counter.sv
// Three-level wrapping x/y/entry coordinate counter with clear, advance and a last flag.
// Shared by the activation loader and the conv output collector.
module act_loader_raster_counter
  import act_loader_pkg::*;
#(
  parameter int MAXD  = 5,
  parameter int NUM_E = 1,
  parameter int W     = IDX_WIDTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         advance_i,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o,
  output logic [W-1:0] e_o,
  output logic         last_o
);

  localparam logic [W-1:0] D_LAST = W'(MAXD - 1);
  localparam logic [W-1:0] E_LAST = W'(NUM_E - 1);

  logic [W-1:0] x_q, x_d, y_q, y_d, e_q, e_d;
  logic         x_wrap, y_wrap;

  assign x_wrap = (x_q == D_LAST);
  assign y_wrap = (y_q == D_LAST);
  assign last_o = x_wrap && y_wrap && (e_q == E_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    e_d = e_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
      e_d = '0;
    end else if (advance_i) begin
      if (x_wrap) begin
        x_d = '0;
        if (y_wrap) begin
          y_d = '0;
          e_d = last_o ? '0 : e_q + W'(1);
        end else begin
          y_d = y_q + W'(1);
        end
      end else begin
        x_d = x_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
      e_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      e_q <= e_d;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
  assign e_o = e_q;

endmodule

// File: rtl/act_loader.sv
// Streams activation words into the conv layer memory in raster order (x, y, entry).
// Define ACT_LOADER_PAD_EN to generate zero border writes of width KERNEL_DIM/2.
module act_loader
  import act_loader_pkg::*;
#(
  parameter int NUM_INPUTS = 1,
  parameter int INPUT_DIM  = 5,
  parameter int KERNEL_DIM = 3,
  parameter int DATA_SIZE  = 64,
  parameter int IDX_W      = IDX_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      in_valid_i,
  input  logic [DATA_SIZE-1:0]      in_data_i,
  output logic                      in_ready_o,
  output logic                      want_write_o,
  output logic [DATA_SIZE-1:0]      write_data_o,
  output logic [2:0][IDX_W-1:0]     in_index_act_o,
  output logic                      busy_o,
  output logic                      done_o
);

`ifdef ACT_LOADER_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int PAD  = PAD_EN ? pad_of(KERNEL_DIM) : 0;
  localparam int MAXD = INPUT_DIM + 2 * PAD;

  state_t                  state_q, state_d;
  logic                    fin_q, fin_d;
  logic                    want_write_q;
  logic [DATA_SIZE-1:0]    write_data_q;
  logic [2:0][IDX_W-1:0]   index_q;

  logic [IDX_W-1:0]        x, y, e;
  logic                    last, is_pad, loading, issue, clear;

  act_loader_raster_counter #(
    .MAXD  (MAXD),
    .NUM_E (NUM_INPUTS),
    .W     (IDX_W)
  ) u_raster (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (clear),
    .advance_i (issue),
    .x_o       (x),
    .y_o       (y),
    .e_o       (e),
    .last_o    (last)
  );

`ifdef ACT_LOADER_PAD_EN
  localparam logic [IDX_W-1:0] LO = IDX_W'(PAD);
  localparam logic [IDX_W-1:0] HI = IDX_W'(PAD + INPUT_DIM);
  assign is_pad = (x < LO) || (x >= HI) || (y < LO) || (y >= HI);
`else
  assign is_pad = 1'b0;
`endif

  // fin_q marks the final write in flight; it stalls the counters until DONE
  assign loading = (state_q == ST_LOAD) && !fin_q;
  assign issue   = loading && (is_pad || in_valid_i);
  assign clear   = (state_q == ST_IDLE) && start_i;

  always_comb begin
    state_d = state_q;
    fin_d   = fin_q;
    case (state_q)
      ST_IDLE: begin
        fin_d = 1'b0;
        if (start_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (fin_q) begin
          state_d = ST_DONE;
          fin_d   = 1'b0;
        end else if (issue && last) begin
          fin_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        fin_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      fin_q        <= 1'b0;
      want_write_q <= 1'b0;
      write_data_q <= '0;
      index_q      <= '0;
    end else begin
      state_q      <= state_d;
      fin_q        <= fin_d;
      want_write_q <= issue;
      if (issue) begin
        write_data_q <= is_pad ? '0 : in_data_i;
        index_q      <= {e, y, x};
      end
    end
  end

  assign in_ready_o     = loading && !is_pad;
  assign want_write_o   = want_write_q;
  assign write_data_o   = write_data_q;
  assign in_index_act_o = index_q;
  assign busy_o         = (state_q == ST_LOAD);
  assign done_o         = (state_q == ST_DONE);

endmodule
